vga_timing_out: RTL and testbench
=================================

// Module: vga_timing_out
// PURPOSE
//  VGA 640x480@60 timing generator and output stage, downstream of the object mux.
//  Issues pixelX/pixelY to every drawing object and the mux. Takes the mux 24-bit RGB back.
//  Drives DAC RGB, sync and blank, delayed to match the upstream pipeline latency.
//  Pulses startOfFrame so game logic can update positions during vertical blanking.
// PARAMETERS
//  H_ACTIVE    640  visible pixels per line
//  H_FP        16   horizontal front porch (clks)
//  H_SYNC      96   hsync width (clks)
//  H_BP        48   horizontal back porch (clks)
//  V_ACTIVE    480  visible lines per frame
//  V_FP        10   vertical front porch (lines)
//  V_SYNC      2    vsync width (lines)
//  V_BP        33   vertical back porch (lines)
//  PIPE_DELAY  1    clks from pixelX/Y to valid redIn/greenIn/blueIn (mux register); legal 0..4
// PORTS
//  clk           in   1   pixel clock (25 MHz nominal)
//  resetN        in   1   asynchronous, active-low reset
//  redIn         in   8   red from object mux
//  greenIn       in   8   green from object mux
//  blueIn        in   8   blue from object mux
//  pixelX        out  11  current horizontal counter, 0..H_TOTAL-1
//  pixelY        out  11  current vertical counter, 0..V_TOTAL-1
//  startOfFrame  out  1   1-clk pulse at start of vertical blanking
//  vgaR          out  8   DAC red
//  vgaG          out  8   DAC green
//  vgaB          out  8   DAC blue
//  vgaHS         out  1   hsync, active low
//  vgaVS         out  1   vsync, active low
//  vgaBlankN     out  1   1 = visible pixel
// BEHAVIOUR
//  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
//  - hCnt increments every clk and wraps H_TOTAL-1 -> 0.
//  - vCnt increments only on the hCnt wrap and wraps V_TOTAL-1 -> 0 on that same clk.
//  - pixelX=hCnt, pixelY=vCnt (registered counters, no extra delay).
//  - Raw timing, combinational from the counters:
//      hsRaw = 0 iff hCnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
//      vsRaw = 0 iff vCnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)
//      visRaw = (hCnt<H_ACTIVE) && (vCnt<V_ACTIVE)
//  - hsRaw/vsRaw/visRaw pass through a PIPE_DELAY-stage shift register, then one output register.
//  - RGB passes through one output register. vgaR/G/B = visDelayed ? xIn : 8'h00.
//  - Net result: all DAC outputs for counter value (X,Y) appear PIPE_DELAY+1 clks after pixelX/Y=(X,Y).
//  - startOfFrame is registered: asserted for exactly 1 clk, the clk after hCnt==0 && vCnt==V_ACTIVE.
//    It is not pipeline-delayed.
//  - Reset (async, any time, including mid-line):
//      hCnt=vCnt=0; all shift stages flushed to inactive (hs=1, vs=1, vis=0);
//      vgaHS=vgaVS=1, vgaBlankN=0, vgaR/G/B=0, startOfFrame=0.
//    Counting restarts from (0,0) on the first clk after release.
//  - No startOfFrame is issued for a frame interrupted by reset.
//    The first pulse is at vCnt==V_ACTIVE of the first full frame.
//  - PIPE_DELAY=0: only the output register remains; latency 1 clk.
//  - Input RGB during blanking is ignored; any value -> 0 out.
// CONFIGURATION
//  TEST_PATTERN_EN defined:
//    Input RGB is replaced, before the output register, by 8 vertical colour bars.
//    Bar index = delayed pixelX[9:7] (80-px bars are not required; 128-px bars, index 0..4 visible).
//    Colour = {8{idx[2]}}, {8{idx[1]}}, {8{idx[0]}}.
//    X is taken from a PIPE_DELAY-delayed copy of hCnt so bars align with sync.
//  TEST_PATTERN_EN undefined: redIn/greenIn/blueIn used; no delayed hCnt copy is built.
// TESTING
//  1 Release reset, run 2 frames -> pixelX/Y wrap at 799/524; exactly one startOfFrame per 420000 clks.
//  2 Count vgaHS low -> 96 clks per line, falling PIPE_DELAY+1 clks after pixelX==656.
//    Count vgaVS low -> 2 lines (1600 clks), starting at line 490.
//  3 PIPE_DELAY=1, drive redIn=8'hAB only when delayed X==5,Y==3 -> vgaR==8'hAB in exactly one clk,
//    2 clks after pixelX==5,Y==3; vgaBlankN=1 in that clk.
//  4 Drive RGB=8'hFF constant -> vgaR/G/B==0 whenever vgaBlankN==0 (e.g. X 640..799 delayed).
//  5 Assert resetN=0 at pixelX=300,Y=200 for 3 clks -> outputs at reset values immediately;
//    pixelX/Y = 0,0 on the first clk after release; no startOfFrame until Y reaches 480.
//  6 TEST_PATTERN_EN defined -> at delayed X=0 RGB=000000, at X=130 RGB=0000FF, at X=300 RGB=00FF00.

Source files
------------

// File: rtl/vga_timing_out.sv
// VGA 640x480@60 timing generator and DAC output stage; sync/blank are delayed to line up with the mux RGB.
// Optional TEST_PATTERN_EN replaces the mux RGB with 8 vertical colour bars indexed by delayed pixelX[9:7].
`timescale 1ns/1ps
module vga_timing_out #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [7:0]  redIn,
  input  logic [7:0]  greenIn,
  input  logic [7:0]  blueIn,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        startOfFrame,
  output logic [7:0]  vgaR,
  output logic [7:0]  vgaG,
  output logic [7:0]  vgaB,
  output logic        vgaHS,
  output logic        vgaVS,
  output logic        vgaBlankN
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
  // Inactive timing word {hs, vs, vis}
  localparam logic [2:0]  TIM_IDLE = 3'b110;

  logic [10:0] r_hcnt;
  logic [10:0] r_vcnt;
  logic        w_hs_raw;
  logic        w_vs_raw;
  logic        w_vis_raw;
  logic [PIPE_DELAY:0][2:0] w_tap;
  logic [2:0]  w_tim_dly;
  logic [7:0]  w_r_src;
  logic [7:0]  w_g_src;
  logic [7:0]  w_b_src;
  logic        r_hs;
  logic        r_vs;
  logic        r_blank_n;
  logic [7:0]  r_red;
  logic [7:0]  r_grn;
  logic [7:0]  r_blu;
  logic        r_sof;

  // Horizontal/vertical raster counters; the line counter advances on the pixel wrap.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_hcnt <= 11'd0;
      r_vcnt <= 11'd0;
    end else if (r_hcnt == H_LAST) begin
      r_hcnt <= 11'd0;
      r_vcnt <= (r_vcnt == V_LAST) ? 11'd0 : r_vcnt + 11'd1;
    end else begin
      r_hcnt <= r_hcnt + 11'd1;
      r_vcnt <= r_vcnt;
    end
  end

  assign w_hs_raw  = !((r_hcnt >= HS_START) && (r_hcnt < HS_END));
  assign w_vs_raw  = !((r_vcnt >= VS_START) && (r_vcnt < VS_END));
  assign w_vis_raw = (r_hcnt < H_VIS) && (r_vcnt < V_VIS);

  assign w_tap[0]  = {w_hs_raw, w_vs_raw, w_vis_raw};

  for (genvar i = 0; i < PIPE_DELAY; i++) begin : g_pipe
    logic [2:0] r_stage;
    // Timing delay stage matching the upstream mux latency; flushed to idle on reset.
    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
        r_stage <= TIM_IDLE;
      end else begin
        r_stage <= w_tap[i];
      end
    end
    assign w_tap[i+1] = r_stage;
  end

  assign w_tim_dly = w_tap[PIPE_DELAY];

`ifdef TEST_PATTERN_EN
  logic [PIPE_DELAY:0][10:0] w_xtap;
  logic [10:0] w_x_dly;
  logic [2:0]  w_bar_idx;

  assign w_xtap[0] = r_hcnt;
  for (genvar j = 0; j < PIPE_DELAY; j++) begin : g_xpipe
    logic [10:0] r_xstage;
    // Delayed pixel column so the bars stay aligned with the delayed sync.
    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
        r_xstage <= 11'd0;
      end else begin
        r_xstage <= w_xtap[j];
      end
    end
    assign w_xtap[j+1] = r_xstage;
  end

  assign w_x_dly   = w_xtap[PIPE_DELAY];
  assign w_bar_idx = w_x_dly[9:7];
  assign w_r_src   = {8{w_bar_idx[2]}};
  assign w_g_src   = {8{w_bar_idx[1]}};
  assign w_b_src   = {8{w_bar_idx[0]}};
`else
  assign w_r_src = redIn;
  assign w_g_src = greenIn;
  assign w_b_src = blueIn;
`endif

  // DAC output register; colour is forced to black outside the visible area.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
      r_blank_n <= 1'b0;
      r_red     <= 8'h00;
      r_grn     <= 8'h00;
      r_blu     <= 8'h00;
      r_sof     <= 1'b0;
    end else begin
      r_hs      <= w_tim_dly[2];
      r_vs      <= w_tim_dly[1];
      r_blank_n <= w_tim_dly[0];
      r_red     <= w_tim_dly[0] ? w_r_src : 8'h00;
      r_grn     <= w_tim_dly[0] ? w_g_src : 8'h00;
      r_blu     <= w_tim_dly[0] ? w_b_src : 8'h00;
      // Frame pulse tracks the live counters, not the delayed pipeline.
      r_sof     <= (r_hcnt == 11'd0) && (r_vcnt == V_VIS);
    end
  end

  assign pixelX       = r_hcnt;
  assign pixelY       = r_vcnt;
  assign startOfFrame = r_sof;
  assign vgaR         = r_red;
  assign vgaG         = r_grn;
  assign vgaB         = r_blu;
  assign vgaHS        = r_hs;
  assign vgaVS        = r_vs;
  assign vgaBlankN    = r_blank_n;

endmodule

// File: tb/tb_vga_timing_out.sv
// Bench for vga_timing_out on a scaled raster (35 x 12, PIPE_DELAY=1): vector table keyed by
// cycle-since-release, sync/frame-pulse counts, and an asynchronous mid-line reset sequence.
`timescale 1ns/1ps
module tb_vga_timing_out;

  localparam int HA = 20, HF = 4, HS = 6, HB = 5;
  localparam int VA = 5,  VF = 2, VS = 2, VB = 3;
  localparam int HT = 35, VT = 12;

`ifdef TEST_PATTERN_EN
  localparam logic [7:0] CG = 8'h00;
  localparam logic [7:0] CR = 8'h00;
`else
  localparam logic [7:0] CG = 8'hFF;
  localparam logic [7:0] CR = 8'hAB;
`endif

  logic        clk = 1'b0;
  logic        resetN;
  logic [7:0]  redIn, greenIn, blueIn;
  logic [10:0] pixelX, pixelY;
  logic        startOfFrame;
  logic [7:0]  vgaR, vgaG, vgaB;
  logic        vgaHS, vgaVS, vgaBlankN;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_timing_out #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PIPE_DELAY(1)
  ) dut (
    .clk(clk), .resetN(resetN),
    .redIn(redIn), .greenIn(greenIn), .blueIn(blueIn),
    .pixelX(pixelX), .pixelY(pixelY), .startOfFrame(startOfFrame),
    .vgaR(vgaR), .vgaG(vgaG), .vgaB(vgaB),
    .vgaHS(vgaHS), .vgaVS(vgaVS), .vgaBlankN(vgaBlankN)
  );

  // n = clock edges since reset release; outputs at n show counter value n-2
  typedef struct {
    int         n;
    int         x;
    int         y;
    logic       hs;
    logic       vs;
    logic       bn;
    logic [7:0] r;
    logic [7:0] g;
    logic       sof;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  task automatic chk(input string nm, input int n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s n=%0d actual=%0h expected=%0h", nm, n, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_x"},   -1, 32'(pixelX), 32'd0);
    chk({nm, "_y"},   -1, 32'(pixelY), 32'd0);
    chk({nm, "_hs"},  -1, 32'(vgaHS), 32'd1);
    chk({nm, "_vs"},  -1, 32'(vgaVS), 32'd1);
    chk({nm, "_bn"},  -1, 32'(vgaBlankN), 32'd0);
    chk({nm, "_rgb"}, -1, {8'h00, vgaR, vgaG, vgaB}, 32'd0);
    chk({nm, "_sof"}, -1, 32'(startOfFrame), 32'd0);
  endtask

  task automatic run_scan(input int ncyc, input bit full, input int exp_sof);
    int hs_low = 0;
    int vs_low = 0;
    int sof_cnt = 0;
    for (int n = 0; n < ncyc; n++) begin
      redIn = (n == 111) ? CR : 8'h00;
      chk("pixel_x", n, 32'(pixelX), 32'(n % HT));
      chk("pixel_y", n, 32'(pixelY), 32'((n / HT) % VT));
      for (int k = 0; k < NV; k++) begin
        if (vecs[k].n == n) begin
          chk("vec_x",   n, 32'(pixelX), 32'(vecs[k].x));
          chk("vec_y",   n, 32'(pixelY), 32'(vecs[k].y));
          chk("vec_hs",  n, 32'(vgaHS), 32'(vecs[k].hs));
          chk("vec_vs",  n, 32'(vgaVS), 32'(vecs[k].vs));
          chk("vec_bn",  n, 32'(vgaBlankN), 32'(vecs[k].bn));
          chk("vec_r",   n, 32'(vgaR), 32'(vecs[k].r));
          chk("vec_g",   n, 32'(vgaG), 32'(vecs[k].g));
          chk("vec_b",   n, 32'(vgaB), 32'(vecs[k].g));
          chk("vec_sof", n, 32'(startOfFrame), 32'(vecs[k].sof));
        end
      end
      if (n >= 2 && n < 2 + HT * VT) begin
        hs_low += (vgaHS == 1'b0) ? 1 : 0;
        vs_low += (vgaVS == 1'b0) ? 1 : 0;
      end
      sof_cnt += (startOfFrame == 1'b1) ? 1 : 0;
      @(negedge clk);
    end
    if (full) begin
      chk("hs_low_per_frame", ncyc, 32'(hs_low), 32'd72);
      chk("vs_low_per_frame", ncyc, 32'(vs_low), 32'd70);
    end
    chk("sof_count", ncyc, 32'(sof_cnt), 32'(exp_sof));
  endtask

  initial begin
    //          n    x   y  hs    vs    bn    r      g      sof
    vecs[0]  = '{0,   0,  0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[1]  = '{1,   1,  0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[2]  = '{2,   2,  0, 1'b1, 1'b1, 1'b1, 8'h00, CG,    1'b0};
    vecs[3]  = '{21,  21, 0, 1'b1, 1'b1, 1'b1, 8'h00, CG,    1'b0};
    vecs[4]  = '{22,  22, 0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[5]  = '{25,  25, 0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[6]  = '{26,  26, 0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[7]  = '{31,  31, 0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[8]  = '{32,  32, 0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[9]  = '{35,  0,  1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[10] = '{37,  2,  1, 1'b1, 1'b1, 1'b1, 8'h00, CG,    1'b0};
    vecs[11] = '{111, 6,  3, 1'b1, 1'b1, 1'b1, 8'h00, CG,    1'b0};
    vecs[12] = '{112, 7,  3, 1'b1, 1'b1, 1'b1, CR,    CG,    1'b0};
    vecs[13] = '{113, 8,  3, 1'b1, 1'b1, 1'b1, 8'h00, CG,    1'b0};
    vecs[14] = '{175, 0,  5, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[15] = '{176, 1,  5, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1};
    vecs[16] = '{177, 2,  5, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[17] = '{246, 1,  7, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[18] = '{247, 2,  7, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[19] = '{273, 28, 7, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[20] = '{316, 1,  9, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[21] = '{317, 2,  9, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[22] = '{419, 34, 11, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[23] = '{420, 0,  0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[24] = '{422, 2,  0, 1'b1, 1'b1, 1'b1, 8'h00, CG,    1'b0};
    vecs[25] = '{596, 1,  5, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1};
    vecs[26] = '{597, 2,  5, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};

    resetN  = 1'b0;
    redIn   = 8'h5A;
    greenIn = 8'hFF;
    blueIn  = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("por");
    resetN = 1'b1;

    // Two full frames plus up to pixel (10,3) of the third
    run_scan(2 * HT * VT + 3 * HT + 10, 1'b1, 2);
    chk("pre_reset_x", -1, 32'(pixelX), 32'd10);
    chk("pre_reset_y", -1, 32'(pixelY), 32'd3);
    chk("pre_reset_bn", -1, 32'(vgaBlankN), 32'd1);

    #2 resetN = 1'b0;
    #1 chk_reset_vals("async_rst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("rst_hold");
    resetN = 1'b1;

    // Restart from (0,0): stale visible stage must be flushed, frame pulse only at line 5
    run_scan(200, 1'b0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
